led_stream_decoder: RTL and testbench
=====================================

Name: led_stream_decoder

Overview:
- Receive-side counterpart of the LED chain driver.
- Samples a single-wire WS2812-style serial stream and classifies each high pulse by width as a 0 or 1 bit.
- Assembles bits MSB-first into 24-bit pixel words, emits one valid strobe per pixel, and detects the low latch gap that ends a frame.
- Used for loopback checking of the display output and for reading an upstream LED chain.

Parameters:
- T_MIN_HIGH, 5: high pulses shorter than this many cycles are glitches and are ignored.
- T_THRESHOLD, 30: a high pulse of at least this many cycles is a 1, otherwise a 0 (at 50 MHz, 0 ≈ 20 cycles, 1 ≈ 40 cycles).
- T_MAX_HIGH, 100: a high pulse longer than this is a protocol error.
- T_RESET, 2500: a low period of this many cycles is the latch gap (50 µs at 50 MHz).
- MAX_PIXELS, 400: pixel capacity per frame; pixels beyond it are dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset
- led_in  in  1  asynchronous serial LED stream
- pixel_data  out  24  last completed pixel, first received bit in bit 23
- pixel_valid  out  1  one-cycle strobe, pixel_data/pixel_index valid
- pixel_index  out  16  position of pixel within the frame, 0-based
- frame_done  out  1  one-cycle strobe on latch gap detection
- frame_pixel_count  out  16  complete pixels in the frame just ended; valid with frame_done, held until next frame_done
- error  out  1  one-cycle strobe on any protocol violation

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: all outputs 0; shift register, bit counter, pixel counter and timers 0; state SYNC.
- Input path: 2-flop synchronizer plus registered edge detect.
- Events are seen 3 clk edges after the edge that first samples the new level of led_in.
- pixel_valid rises 1 cycle after the falling-edge event of the 24th bit.
- States:
  - SYNC: ignore all pulses. Count consecutive low cycles; a high resets the count. When the count reaches T_RESET, go to IDLE. No frame_done on this exit.
  - IDLE: on rising edge, clear high_cnt and go to HIGH.
  - HIGH: high_cnt increments, saturating at T_MAX_HIGH+1.
    - high_cnt > T_MAX_HIGH: pulse error, drop the partial pixel, go to SYNC.
    - Falling edge with high_cnt < T_MIN_HIGH: discard, go to LOW.
    - Otherwise: shift in bit = (high_cnt >= T_THRESHOLD), bit_cnt++, go to LOW.
    - If bit_cnt wraps 23 → 0: pulse pixel_valid with pixel_data and pixel_index = pixel_cnt, then increment pixel_cnt.
  - LOW: low_cnt increments, saturating at T_RESET.
    - Rising edge before T_RESET: clear high_cnt, go to HIGH.
    - low_cnt == T_RESET: pulse frame_done, set frame_pixel_count = pixel_cnt, clear pixel_cnt, go to IDLE.
    - If bit_cnt != 0 at that point, also pulse error and discard the partial bits.
- Overflow: a pixel completing with pixel_cnt == MAX_PIXELS pulses error instead of pixel_valid. pixel_cnt saturates; the frame continues.
- Simultaneous events: error and frame_done may assert in the same cycle; pixel_valid and error never do.
- rst mid-frame: everything clears, back to SYNC. A full T_RESET low is required before decoding resumes.
- Stream high at reset release: remains in SYNC, no error.

Decomposition:
- Package led_stream_defs:
  - state enum {SYNC, IDLE, HIGH, LOW}
  - packed pixel struct {g[7:0], r[7:0], b[7:0]}
  - PIXEL_BITS = 24
- Sub-module led_input_sync: 2-flop synchronizer with registered rise/fall strobes and level output.

Test Plan:
- Stream 2500 low, then 24 bits of 0x0F0000 (1-bits 40 high/22 low, 0-bits 20/42), then 2500 low → pixel_data=0x0F0000, pixel_index=0 once; then frame_done with frame_pixel_count=1; error never asserted.
- Gap, then 3 pixels 0x123456, 0xABCDEF, 0x000001, then gap → three pixel_valid strobes with indices 0, 1, 2 and matching data; frame_done count=3; second identical frame gives the same indices.
- Gap, 12 bits, gap → no pixel_valid; error and frame_done in the same cycle, count=0; next full frame decodes correctly.
- Gap, then a 120-cycle high → error once, ~T_MAX_HIGH+4 cycles after the rise. Pulses before the next 2500-cycle low are ignored; a subsequent pixel decodes normally.
- Gap, then 2-cycle glitches between bits of 0xFF00FF → glitches ignored, pixel_data=0xFF00FF. With MAX_PIXELS=2 and 3 pixels sent → 2 pixel_valid, 1 error, frame_pixel_count=2.
- Pulses before any initial gap → no outputs. Assert rst after 10 bits of a pixel → outputs 0, state SYNC, no pixel until gap plus a full 24 bits.

Source files
------------

// File: rtl/led_stream_decoder_pkg.sv
// Shared types and constants for the LED stream decoder.
package led_stream_defs;

  localparam int unsigned PIXEL_BITS = 24;
  localparam int unsigned BIT_CNT_W  = 5;
  localparam int unsigned INDEX_W    = 16;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/led_stream_decoder_input_sync.sv
// Two-flop synchronizer for the serial LED line with registered edge strobes.
module led_input_sync (
  input  logic clk,
  input  logic rst,
  input  logic led_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronize the line and flag each transition for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta_q <= led_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      level  <= sync_q;
      rise   <= sync_q & ~prev_q;
      fall   <= ~sync_q & prev_q;
    end
  end

endmodule

// File: rtl/led_stream_decoder.sv
// Decodes a WS2812-style single-wire stream into 24-bit pixels and frame boundaries.
module led_stream_decoder
  import led_stream_defs::*;
#(
  parameter int unsigned T_MIN_HIGH  = 5,
  parameter int unsigned T_THRESHOLD = 30,
  parameter int unsigned T_MAX_HIGH  = 100,
  parameter int unsigned T_RESET     = 2500,
  parameter int unsigned MAX_PIXELS  = 400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  led_in,
  output logic [PIXEL_BITS-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic [INDEX_W-1:0]    pixel_index,
  output logic                  frame_done,
  output logic [INDEX_W-1:0]    frame_pixel_count,
  output logic                  error
);

  localparam int unsigned HCW = $clog2(T_MAX_HIGH + 2);
  localparam int unsigned LCW = $clog2(T_RESET + 1);

  logic lvl;
  logic rise;
  logic fall;

  led_input_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .led_in (led_in),
    .level  (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  state_e                  state_q,  state_nxt;
  logic [HCW-1:0]          high_q,   high_nxt;
  logic [LCW-1:0]          low_q,    low_nxt;
  logic [BIT_CNT_W-1:0]    bit_q,    bit_nxt;
  logic [PIXEL_BITS-1:0]   shift_q,  shift_nxt;
  logic [INDEX_W-1:0]      pcnt_q,   pcnt_nxt;
  pixel_t                  pdata_q,  pdata_nxt;
  logic [INDEX_W-1:0]      pidx_q,   pidx_nxt;
  logic [INDEX_W-1:0]      fcount_q, fcount_nxt;
  logic                    pvalid_q, pvalid_nxt;
  logic                    fdone_q,  fdone_nxt;
  logic                    err_q,    err_nxt;
  logic                    bit_val;
  logic [PIXEL_BITS-1:0]   word;

  // Next-state, counter and strobe logic; everything holds unless a state acts.
  always_comb begin
    state_nxt  = state_q;
    high_nxt   = high_q;
    low_nxt    = low_q;
    bit_nxt    = bit_q;
    shift_nxt  = shift_q;
    pcnt_nxt   = pcnt_q;
    pdata_nxt  = pdata_q;
    pidx_nxt   = pidx_q;
    fcount_nxt = fcount_q;
    pvalid_nxt = 1'b0;
    fdone_nxt  = 1'b0;
    err_nxt    = 1'b0;
    bit_val    = (high_q >= HCW'(T_THRESHOLD));
    word       = {shift_q[PIXEL_BITS-2:0], bit_val};

    case (state_q)
      SYNC: begin
        // Wait for one unbroken latch-length low before trusting the stream.
        if (lvl) begin
          low_nxt = '0;
        end else if (low_q >= LCW'(T_RESET - 1)) begin
          low_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          low_nxt = low_q + LCW'(1);
        end
      end

      IDLE: begin
        if (rise) begin
          high_nxt  = '0;
          state_nxt = HIGH;
        end
      end

      HIGH: begin
        if (high_q > HCW'(T_MAX_HIGH)) begin
          // Stuck-high line: abandon the frame and resynchronize.
          err_nxt   = 1'b1;
          bit_nxt   = '0;
          shift_nxt = '0;
          pcnt_nxt  = '0;
          low_nxt   = '0;
          state_nxt = SYNC;
        end else if (fall) begin
          low_nxt   = '0;
          state_nxt = LOW;
          if (high_q >= HCW'(T_MIN_HIGH)) begin
            shift_nxt = word;
            if (bit_q == BIT_CNT_W'(PIXEL_BITS - 1)) begin
              bit_nxt = '0;
              if (pcnt_q == INDEX_W'(MAX_PIXELS)) begin
                err_nxt = 1'b1;
              end else begin
                pvalid_nxt = 1'b1;
                pdata_nxt  = pixel_t'(word);
                pidx_nxt   = pcnt_q;
                pcnt_nxt   = pcnt_q + INDEX_W'(1);
              end
            end else begin
              bit_nxt = bit_q + BIT_CNT_W'(1);
            end
          end
        end else begin
          high_nxt = high_q + HCW'(1);
        end
      end

      LOW: begin
        if (rise) begin
          high_nxt  = '0;
          state_nxt = HIGH;
        end else if (low_q == LCW'(T_RESET)) begin
          // Latch gap: close the frame, flagging any dangling partial pixel.
          fdone_nxt  = 1'b1;
          fcount_nxt = pcnt_q;
          err_nxt    = (bit_q != '0);
          bit_nxt    = '0;
          shift_nxt  = '0;
          pcnt_nxt   = '0;
          state_nxt  = IDLE;
        end else begin
          low_nxt = low_q + LCW'(1);
        end
      end

      default: state_nxt = SYNC;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SYNC;
      high_q   <= '0;
      low_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pcnt_q   <= '0;
      pdata_q  <= '0;
      pidx_q   <= '0;
      fcount_q <= '0;
      pvalid_q <= 1'b0;
      fdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      high_q   <= high_nxt;
      low_q    <= low_nxt;
      bit_q    <= bit_nxt;
      shift_q  <= shift_nxt;
      pcnt_q   <= pcnt_nxt;
      pdata_q  <= pdata_nxt;
      pidx_q   <= pidx_nxt;
      fcount_q <= fcount_nxt;
      pvalid_q <= pvalid_nxt;
      fdone_q  <= fdone_nxt;
      err_q    <= err_nxt;
    end
  end

  assign pixel_data        = pdata_q;
  assign pixel_valid       = pvalid_q;
  assign pixel_index       = pidx_q;
  assign frame_done        = fdone_q;
  assign frame_pixel_count = fcount_q;
  assign error             = err_q;

endmodule

// File: tb/tb_led_stream_decoder.sv
// Scoreboard bench for led_stream_decoder driven by hand-built pulse streams.
module tb_led_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        led;

  logic [23:0] pdata0,  pdata1;
  logic        pv0,     pv1;
  logic [15:0] pidx0,   pidx1;
  logic        fd0,     fd1;
  logic [15:0] fcnt0,   fcnt1;
  logic        err0,    err1;

  always #5 clk = ~clk;

  led_stream_decoder u_dut (
    .clk               (clk),
    .rst               (rst),
    .led_in            (led),
    .pixel_data        (pdata0),
    .pixel_valid       (pv0),
    .pixel_index       (pidx0),
    .frame_done        (fd0),
    .frame_pixel_count (fcnt0),
    .error             (err0)
  );

  led_stream_decoder #(.MAX_PIXELS(2)) u_dut_small (
    .clk               (clk),
    .rst               (rst),
    .led_in            (led),
    .pixel_data        (pdata1),
    .pixel_valid       (pv1),
    .pixel_index       (pidx1),
    .frame_done        (fd1),
    .frame_pixel_count (fcnt1),
    .error             (err1)
  );

  typedef enum int {K_PIX, K_FD, K_ERR, K_ERRFD} kind_e;
  typedef struct {
    kind_e       kind;
    logic [23:0] data;
    logic [15:0] num;
  } exp_t;

  exp_t sb[$];
  exp_t obs;
  exp_t exp_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   pv1_cnt = 0;
  int   err1_cnt = 0;
  int   fd1_cnt = 0;
  logic [15:0] fcnt1_seen = '0;
  int   b_pv, b_err, b_fd;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push(input kind_e k, input logic [23:0] d, input logic [15:0] n);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.num  = n;
    sb.push_back(e);
  endtask

  // Observe both DUTs on the falling edge and match main-DUT events to the queue.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv1) pv1_cnt++;
        if (err1) err1_cnt++;
        if (fd1) begin
          fd1_cnt++;
          fcnt1_seen = fcnt1;
        end
        if (pv0 || fd0 || err0) begin
          obs.data = '0;
          obs.num  = '0;
          if (pv0 && err0) begin
            n_vec++;
            n_bad++;
            $display("FAIL strobe_overlap: pixel_valid and error both high at %0t", $time);
          end
          if (pv0) begin
            obs.kind = K_PIX;
            obs.data = pdata0;
            obs.num  = pidx0;
          end else if (err0 && fd0) begin
            obs.kind = K_ERRFD;
            obs.num  = fcnt0;
          end else if (fd0) begin
            obs.kind = K_FD;
            obs.num  = fcnt0;
          end else begin
            obs.kind = K_ERR;
          end
          n_vec++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got %s data=%h num=%0d, queue empty at %0t",
                     obs.kind.name(), obs.data, obs.num, $time);
          end else begin
            exp_e = sb.pop_front();
            if (exp_e.kind != obs.kind || exp_e.data !== obs.data || exp_e.num !== obs.num) begin
              n_bad++;
              $display("FAIL event: got %s data=%h num=%0d, expected %s data=%h num=%0d at %0t",
                       obs.kind.name(), obs.data, obs.num,
                       exp_e.kind.name(), exp_e.data, exp_e.num, $time);
            end
          end
        end
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    led = v;
    repeat (n) @(negedge clk);
  endtask

  // One bit cell of 62 cycles, optionally with a 2-cycle glitch in the low part.
  task automatic send_bit(input logic b, input bit glitch);
    hold(1'b1, b ? 40 : 20);
    if (glitch) begin
      hold(1'b0, 10);
      hold(1'b1, 2);
      hold(1'b0, (b ? 22 : 42) - 12);
    end else begin
      hold(1'b0, b ? 22 : 42);
    end
  endtask

  task automatic send_bits(input logic [23:0] p, input int nbits, input bit glitch);
    for (int i = 23; i > 23 - nbits; i--) send_bit(p[i], glitch);
  endtask

  task automatic send_pixel(input logic [23:0] p, input logic [15:0] idx);
    push(K_PIX, p, idx);
    send_bits(p, 24, 1'b0);
  endtask

  task automatic gap();
    hold(1'b0, 2600);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pixel_data"},  pdata0, 24'h0);
    check({tag, "_pixel_valid"}, 24'(pv0), 24'h0);
    check({tag, "_pixel_index"}, 24'(pidx0), 24'h0);
    check({tag, "_frame_done"},  24'(fd0), 24'h0);
    check({tag, "_frame_count"}, 24'(fcnt0), 24'h0);
    check({tag, "_error"},       24'(err0), 24'h0);
  endtask

  initial begin
    rst = 1'b1;
    led = 1'b0;
    fork
      monitor();
    join_none
    repeat (4) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Pulses before the first latch gap are not decoded.
    send_bits(24'hFFFFFF, 6, 1'b0);
    gap();

    // Single pixel frame.
    send_pixel(24'h0F0000, 16'd0);
    push(K_FD, 24'h0, 16'd1);
    gap();

    // Two identical three-pixel frames.
    for (int f = 0; f < 2; f++) begin
      send_pixel(24'h123456, 16'd0);
      send_pixel(24'hABCDEF, 16'd1);
      send_pixel(24'h000001, 16'd2);
      push(K_FD, 24'h0, 16'd3);
      gap();
    end

    // Partial pixel at the gap: error and frame_done together, count 0.
    send_bits(24'hA5C300, 12, 1'b0);
    push(K_ERRFD, 24'h0, 16'd0);
    gap();
    send_pixel(24'h5A5AA5, 16'd0);
    push(K_FD, 24'h0, 16'd1);
    gap();

    // Stuck-high pulse, then ignored pulses until a fresh gap.
    push(K_ERR, 24'h0, 16'd0);
    hold(1'b1, 120);
    hold(1'b0, 30);
    send_bits(24'hFFFFFF, 5, 1'b0);
    gap();
    send_pixel(24'h00C3FF, 16'd0);
    push(K_FD, 24'h0, 16'd1);
    gap();

    // Glitches between bits are discarded.
    push(K_PIX, 24'hFF00FF, 16'd0);
    send_bits(24'hFF00FF, 24, 1'b1);
    push(K_FD, 24'h0, 16'd1);
    gap();

    // Overflow on the two-pixel instance while the main one takes all three.
    b_pv  = pv1_cnt;
    b_err = err1_cnt;
    b_fd  = fd1_cnt;
    send_pixel(24'h111111, 16'd0);
    send_pixel(24'h222222, 16'd1);
    send_pixel(24'h333333, 16'd2);
    push(K_FD, 24'h0, 16'd3);
    gap();
    check("ovf_valid_count", 24'(pv1_cnt - b_pv), 24'd2);
    check("ovf_error_count", 24'(err1_cnt - b_err), 24'd1);
    check("ovf_frame_done",  24'(fd1_cnt - b_fd), 24'd1);
    check("ovf_frame_count", 24'(fcnt1_seen), 24'd2);

    // Reset in the middle of a pixel, then no decode until a gap.
    send_bits(24'hC0FFEE, 10, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_cleared("midrst");
    rst = 1'b0;
    send_bits(24'hFFFFFF, 24, 1'b0);
    gap();
    send_pixel(24'h13579B, 16'd0);
    push(K_FD, 24'h0, 16'd1);
    gap();

    hold(1'b0, 300);
    check("scoreboard_drained", 24'(sb.size()), 24'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
